// File: rtl/mssd_pkg.sv
// Shared MSSD link definitions: field widths, line levels, FSM states
// and the hex-to-7-segment decoder used by the transmitter and receiver.
package mssd_pkg;

  localparam int MSSD_PORT_W = 2;
  localparam int MSSD_LEN_W  = 4;
  localparam int MSSD_DATA_W = 16;

  localparam logic MSSD_IDLE_LEVEL  = 1'b1;
  localparam logic MSSD_START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PORT,
    S_LEN,
    S_DATA,
    S_FINISH
  } mssd_state_e;

  // Active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] mssd_hex_ssd(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mssd_step_sync.sv
// Push-button step synchronizer: two metastability flops plus one
// history flop, producing a single-cycle pulse per rising edge.
module mssd_step_sync (
  input  logic clock,
  input  logic reset,
  input  logic step,
  output logic step_rise
);

  logic [2:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], step};
    end
  end

  assign step_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/mssd_packet_tx.sv
// MSSD serial packet transmitter, one bit per synchronized step edge.
// Define MSSD_TX_SSD_EN to drive ssd_remaining from the payload counter.
module mssd_packet_tx
  import mssd_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [MSSD_PORT_W-1:0] port,
  input  logic [MSSD_LEN_W-1:0]  len,
  input  logic [MSSD_DATA_W-1:0] data,
  input  logic                   step,
  output logic                   SerOut,
  output logic                   busy,
  output logic                   done,
  output logic [6:0]             ssd_remaining
);

  mssd_state_e state_q, state_d;
  logic ser_q, ser_d;
  logic [MSSD_LEN_W-1:0]  cnt_q, cnt_d;
  logic [MSSD_PORT_W-1:0] port_q, port_d;
  logic [MSSD_LEN_W-1:0]  len_q, len_d;
  logic [MSSD_DATA_W-1:0] data_q, data_d;
  logic step_rise;
  logic [1:0] len_idx;
  logic [3:0] first_idx;
  logic [3:0] next_idx;

  mssd_step_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .step      (step),
    .step_rise (step_rise)
  );

  assign len_idx   = cnt_q[1:0] - 2'd1;
  assign first_idx = len_q - 4'd1;
  assign next_idx  = cnt_q - 4'd2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ser_q   <= MSSD_IDLE_LEVEL;
      cnt_q   <= '0;
      port_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ser_q   <= ser_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    len_d   = len_q;
    data_d  = data_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ser_d = MSSD_IDLE_LEVEL;
        if (start) begin
          port_d  = port;
          len_d   = len;
          data_d  = data;
          ser_d   = MSSD_START_LEVEL;
          state_d = S_START;
        end
      end
      S_START: begin
        if (step_rise) begin
          state_d = S_PORT;
          ser_d   = port_q[1];
          cnt_d   = 4'd1;
        end
      end
      S_PORT: begin
        if (step_rise) begin
          if (cnt_q == '0) begin
            state_d = S_LEN;
            ser_d   = len_q[3];
            cnt_d   = 4'd3;
          end else begin
            cnt_d = cnt_q - 4'd1;
            ser_d = port_q[0];
          end
        end
      end
      S_LEN: begin
        if (step_rise) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
            ser_d = len_q[len_idx];
          end else if (len_q == '0) begin
            state_d = S_FINISH;
            ser_d   = MSSD_IDLE_LEVEL;
          end else begin
            state_d = S_DATA;
            ser_d   = data_q[first_idx];
            cnt_d   = len_q;
          end
        end
      end
      S_DATA: begin
        // cnt_q counts payload bits not yet sampled, including the one on the line
        if (step_rise) begin
          if (cnt_q == 4'd1) begin
            state_d = S_FINISH;
            ser_d   = MSSD_IDLE_LEVEL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            ser_d = data_q[next_idx];
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        ser_d   = MSSD_IDLE_LEVEL;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = MSSD_IDLE_LEVEL;
      end
    endcase
  end

  assign SerOut = ser_q;
  assign busy   = (state_q != S_IDLE);

`ifdef MSSD_TX_SSD_EN
  assign ssd_remaining = (state_q == S_DATA) ? mssd_hex_ssd(cnt_q) : 7'b0000000;
`else
  assign ssd_remaining = 7'b0000000;
`endif

endmodule

// File: tb/tb_mssd_packet_tx.sv
// Scoreboard bench for mssd_packet_tx: expected line bits are queued by
// the stimulus and checked by a monitor on each rising step edge.
module tb_mssd_packet_tx;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  port;
  logic [3:0]  len;
  logic [15:0] data;
  logic        step;
  logic        SerOut;
  logic        busy;
  logic        done;
  logic [6:0]  ssd_remaining;

  typedef struct {
    logic       bit_v;
    logic [6:0] ssd;
  } exp_t;

  exp_t exp_q[$];
  int checks;
  int errors;
  int done_cnt;

  mssd_packet_tx dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .port          (port),
    .len           (len),
    .data          (data),
    .step          (step),
    .SerOut        (SerOut),
    .busy          (busy),
    .done          (done),
    .ssd_remaining (ssd_remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] exp_ssd(input int rem);
`ifdef MSSD_TX_SSD_EN
    logic [6:0] s;
    case (rem)
      1: s = 7'h06;   2: s = 7'h5B;   3: s = 7'h4F;   4: s = 7'h66;
      5: s = 7'h6D;   6: s = 7'h7D;   7: s = 7'h07;   8: s = 7'h7F;
      9: s = 7'h6F;   10: s = 7'h77;  11: s = 7'h7C;  12: s = 7'h39;
      13: s = 7'h5E;  14: s = 7'h79;  15: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
`else
    return (rem < 0) ? 7'h7F : 7'h00;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue a hand-written packet bit string; n = 7 + nlen
  task automatic push_vec(input logic [31:0] v, input int n, input int nlen);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.bit_v = v[n-1-i];
      e.ssd = exp_ssd((i >= 7) ? nlen - (i - 7) : 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic press(input int hold);
    @(negedge clock);
    step = 1'b1;
    repeat (hold) @(negedge clock);
    step = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic presses(input int n);
    for (int i = 0; i < n; i++) press(4);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clock);
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic accept(input string name);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    chk({name, "_accept_ser"}, SerOut, 1'b0);
    chk({name, "_accept_busy"}, busy, 1'b1);
    @(negedge clock);
    start = 1'b0;
  endtask

  always @(posedge step) begin
    exp_t e;
    if (busy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_bit: line %0b sampled with empty queue", SerOut);
      end else begin
        e = exp_q.pop_front();
        if (SerOut !== e.bit_v || ssd_remaining !== e.ssd) begin
          errors++;
          $display("FAIL line_bit: got ser=%0b ssd=%0h expected ser=%0b ssd=%0h",
                   SerOut, ssd_remaining, e.bit_v, e.ssd);
        end
      end
    end
  end

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  initial begin
    int d0;
    checks = 0;
    errors = 0;
    done_cnt = 0;
    reset = 1'b1;
    start = 1'b0;
    port = 2'd0;
    len = 4'd0;
    data = 16'h0000;
    step = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_ser", SerOut, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ssd", ssd_remaining, 7'h00);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    press(4);
    chk("idle_step_ser", SerOut, 1'b1);
    chk("idle_step_busy", busy, 1'b0);

    // port=2 len=3 data=5, one long press, mid-packet start ignored
    d0 = done_cnt;
    port = 2'd2; len = 4'd3; data = 16'h0005;
    push_vec(32'b0100011101, 10, 3);
    accept("t1");
    port = 2'd0; len = 4'd0; data = 16'h0000;
    presses(3);
    press(50);
    @(negedge clock);
    port = 2'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    presses(6);
    wait_idle("t1_idle");
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_ser_after", SerOut, 1'b1);
    chk("t1_queue", exp_q.size(), 0);

    // zero-length payload
    d0 = done_cnt;
    port = 2'd1; len = 4'd0; data = 16'hFFFF;
    push_vec(32'b0010000, 7, 0);
    accept("t2");
    presses(7);
    wait_idle("t2_idle");
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_queue", exp_q.size(), 0);

    // maximum length payload
    d0 = done_cnt;
    port = 2'd0; len = 4'd15; data = 16'h7FFF;
    push_vec(32'b0001111111111111111111, 22, 15);
    accept("t3");
    presses(22);
    wait_idle("t3_idle");
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_queue", exp_q.size(), 0);
    chk("t3_ssd_after", ssd_remaining, 7'h00);

    // reset during DATA aborts
    d0 = done_cnt;
    port = 2'd3; len = 4'd8; data = 16'h00A5;
    push_vec(32'b011100010100101, 15, 8);
    accept("t4");
    presses(9);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ser", SerOut, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clock);
    chk("abort_no_done", done_cnt - d0, 0);

    // clean packet after reset
    push_vec(32'b011100010100101, 15, 8);
    accept("t5");
    presses(15);
    wait_idle("t5_idle");
    chk("t5_done", done_cnt - d0, 1);
    chk("t5_queue", exp_q.size(), 0);

    // start held across FINISH starts the next packet straight away
    d0 = done_cnt;
    port = 2'd1; len = 4'd0; data = 16'h0000;
    push_vec(32'b0010000, 7, 0);
    push_vec(32'b0010000, 7, 0);
    accept("t6");
    start = 1'b1;
    presses(6);
    @(negedge clock);
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clock);
    end
    chk("t6_done_seen", done, 1'b1);
    step = 1'b0;
    @(negedge clock);
    chk("t6_gap_busy", busy, 1'b0);
    @(negedge clock);
    chk("t6_restart_busy", busy, 1'b1);
    chk("t6_restart_ser", SerOut, 1'b0);
    start = 1'b0;
    repeat (4) @(negedge clock);
    presses(7);
    wait_idle("t6_idle");
    chk("t6_done", done_cnt - d0, 2);
    chk("t6_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mssd_packet_tx.md
# mssd_packet_tx

Serial packet transmitter for the multi-port serial-to-SSD link. It emits packets in the exact format the MSSD receiver consumes: start bit, 2-bit destination port, 4-bit payload length, then the payload bits, all MSB first. It advances one bit per push-button step, so a board running this block can drive a second board's MSSD receiver with no other glue. It sits between a switch/register front end and the `SerIn` pin of the receiving board.

## Interface
- No parameters; field widths are fixed by the protocol (shared package constants).
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; a packet is accepted when high while idle.
- `port`  in  2  destination port, captured on accept.
- `len`  in  4  payload length N (0..15), captured on accept.
- `data`  in  16  payload; bits `data[N-1]` down to `data[0]` are sent; captured on accept.
- `step`  in  1  raw push-button bit clock, asynchronous to `clock`.
- `SerOut`  out  1  serial line, idles high.
- `busy`  out  1  high from accept until return to idle.
- `done`  out  1  one-cycle pulse when a packet completes.
- `ssd_remaining`  out  7  active-high segments {g..a}, hex count of payload bits still to send.

## Operation
- Line format, per packet: `0`, `port[1]`, `port[0]`, `len[3:0]` MSB first, then N payload bits MSB first. Total bits = 7 + N.
- `step` passes through a 2-FF synchronizer, then rising-edge detection; one detected edge = one advance. Holding `step` high gives exactly one advance.
- States: IDLE, START, PORT, LEN, DATA, FINISH.
  - IDLE: `SerOut`=1, `busy`=0. When `start`=1, capture port/len/data, drive `SerOut`=0, go to START.
  - START: on edge, go to PORT, drive `port[1]`.
  - PORT: 2-bit down-counter. On each edge, present the next bit. After `port[0]`'s edge, go to LEN, drive `len[3]`.
  - LEN: same scheme for 4 bits. After the `len[0]` edge, go to DATA with `data[N-1]`, or go straight to FINISH if N=0.
  - DATA: a 4-bit remaining counter starts at N. Each edge decrements it and shifts out the next bit. When the edge lands with the counter at 1, go to FINISH.
  - FINISH: `SerOut`=1 and `done`=1 for one cycle, then IDLE.
- The bit for each position is on `SerOut` before the step edge the receiver samples. The transmitter moves on only after detecting that edge.
- `start` is ignored while `busy`=1. Inputs may change freely after accept.
- An edge detected in IDLE is ignored.
- If `start` is high in the same cycle FINISH returns to IDLE, the new packet is accepted on the following cycle (earliest: the cycle after `done`).
- `reset` asserted mid-packet aborts at once: line returns high and no `done` is produced.

## Timing
- Reset values: `SerOut`=1, `busy`=0, `done`=0, `ssd_remaining`=0, synchronizer flops 0, state IDLE.
- Accept: `start` sampled high at clock edge k gives `SerOut`=0 and `busy`=1 after edge k.
- Step latency: with `step` first sampled high at edge k, the next bit appears on `SerOut` after edge k+2.
- Completion: the final edge's k+2 update enters FINISH, so `done` is high for the cycle after edge k+2. `busy` falls after edge k+3.

## Configuration
- `MSSD_TX_SSD_EN` defined: a hex-to-7-segment decoder drives `ssd_remaining` from the remaining counter.
  - It shows N during LEN→DATA hand-off and counts down through DATA.
  - It reads 0 in all other states.
- Not defined: `ssd_remaining` is tied to 7'b0000000 and the decoder is not instantiated. Line behaviour is identical.

## Structure
- Shared package `mssd_pkg`:
  - state enum;
  - `MSSD_PORT_W`=2, `MSSD_LEN_W`=4, `MSSD_DATA_W`=16;
  - `MSSD_IDLE_LEVEL`=1, `MSSD_START_LEVEL`=0.
- Sub-module `mssd_step_sync`: 2-FF synchronizer plus rising-edge pulse, async reset. It is reusable by the receiver.
- The hex-to-SSD decoder function also lives in `mssd_pkg`.

## Test plan
- port=2, len=3, data=16'h0005, 10 step presses → `SerOut` sequence 0,1,0,0,0,1,1,1,0,1. `done` pulses once after the 10th press, `SerOut`=1 after.
- port=1, len=0, 7 presses → sequence 0,0,1,0,0,0,0. `done` after the 7th press with no DATA state. `ssd_remaining`=0 throughout.
- len=15, data=16'h7FFF, 22 presses → 15 ones after the header. With the macro defined, `ssd_remaining` steps F→0. `done` after the 22nd press.
- `step` held high for 50 clocks → exactly one bit advance. `start` pulsed mid-packet with different port → ignored, original packet completes.
- `reset` asserted during DATA → `SerOut`=1, `busy`=0, no `done`. A new `start` afterwards sends a clean full packet.
- Step edge in IDLE → no line change. `start` held high across FINISH → second packet begins the cycle after `done`.
